dispatch_stage: RTL and testbench

DISPATCH_STAGE -- requirements
Module: dispatch_stage

---
 rtl/core_pkg.sv | 59 +++++
 rtl/dispatch_stage_if.sv | 52 +++++
 rtl/dispatch_stage_decode.sv | 42 ++++
 rtl/dispatch_stage.sv | 92 +++++++++
 tb/tb_dispatch_stage.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared encodings for the decode -> dispatch path: unit select, ALU op classes,
// ALU control codes and the word held in each dispatch register.
package core_pkg;

    localparam int DU_W         = 4;
    localparam int ALU_OP_W     = 2;
    localparam int ALU_CTRL_W   = 4;
    localparam int IMM_SRC_W    = 3;
    localparam int RESULT_SRC_W = 2;
    localparam int FUNCT3_W     = 3;
    localparam int N_UNITS      = 9;

    // Codes 9..15 select no unit; such bundles still flow through as NOPs.
    typedef enum logic [DU_W-1:0] {
        DU_SHORT_ALU = 4'd0,
        DU_LONG_ALU  = 4'd1,
        DU_BRANCH    = 4'd2,
        DU_CACHE_RD  = 4'd3,
        DU_CACHE_WR  = 4'd4,
        DU_SHORT_FPU = 4'd5,
        DU_LONG_FPU  = 4'd6,
        DU_INPUT     = 4'd7,
        DU_OUTPUT    = 4'd8
    } dispatch_unit_e;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_OP_ADD   = 2'b00,
        ALU_OP_SUB   = 2'b01,
        ALU_OP_FUNCT = 2'b10,
        ALU_OP_CMP   = 2'b11
    } alu_op_e;

    localparam logic [ALU_CTRL_W-1:0] ALU_CTRL_ADD = 4'b0000;
    localparam logic [ALU_CTRL_W-1:0] ALU_CTRL_SUB = 4'b1000;

    typedef struct packed {
        logic [N_UNITS-1:0]      unit_en;
        logic [ALU_CTRL_W-1:0]   alu_control;
        logic                    alu_op_and;
        logic                    funct3_0;
        logic                    jump;
        logic                    rs_fpu;
        logic                    alu_src;
        logic                    store_src;
        logic                    reg_write;
        logic                    fpu_reg_write;
        logic [RESULT_SRC_W-1:0] result_src;
    } disp_word_t;

    function automatic logic [N_UNITS-1:0] unit_onehot(input logic [DU_W-1:0] du);
        logic [N_UNITS-1:0] oh;
        oh = '0;
        for (int i = 0; i < N_UNITS; i++) begin
            oh[i] = (du == DU_W'(i));
        end
        return oh;
    endfunction

endpackage

// File: rtl/dispatch_stage_if.sv
// Decode-side and dispatch-side control bundles. The stage consumes the decoder's
// "out" view and produces the dispatch "in" view seen by the execution units.
interface control_decode_io;
    import core_pkg::*;
    logic                    jump;
    logic                    rs_fpu;
    logic [DU_W-1:0]         dispatch_unit;
    logic [ALU_OP_W-1:0]     alu_op;
    logic [IMM_SRC_W-1:0]    imm_src;
    logic                    alu_src;
    logic                    store_src;
    logic                    reg_write;
    logic                    fpu_reg_write;
    logic [RESULT_SRC_W-1:0] result_src;
    logic [FUNCT3_W-1:0]     funct3;
    logic                    op_5_xor_6;

    modport master (output jump, rs_fpu, dispatch_unit, alu_op, imm_src, alu_src, store_src,
                           reg_write, fpu_reg_write, result_src, funct3, op_5_xor_6);
    modport out    (input  jump, rs_fpu, dispatch_unit, alu_op, imm_src, alu_src, store_src,
                           reg_write, fpu_reg_write, result_src, funct3, op_5_xor_6);
endinterface

interface control_dispatch_io;
    import core_pkg::*;
    logic                    short_alu_en;
    logic                    long_alu_en;
    logic                    branch_en;
    logic                    cache_re;
    logic                    cache_we;
    logic                    short_fpu_en;
    logic                    long_fpu_en;
    logic                    input_en;
    logic                    output_en;
    logic [ALU_CTRL_W-1:0]   alu_control;
    logic                    alu_op_and;
    logic                    funct3_0;
    logic                    jump;
    logic                    rs_fpu;
    logic                    alu_src;
    logic                    store_src;
    logic                    reg_write;
    logic                    fpu_reg_write;
    logic [RESULT_SRC_W-1:0] result_src;

    modport in    (output short_alu_en, long_alu_en, branch_en, cache_re, cache_we, short_fpu_en,
                          long_fpu_en, input_en, output_en, alu_control, alu_op_and, funct3_0,
                          jump, rs_fpu, alu_src, store_src, reg_write, fpu_reg_write, result_src);
    modport slave (input  short_alu_en, long_alu_en, branch_en, cache_re, cache_we, short_fpu_en,
                          long_fpu_en, input_en, output_en, alu_control, alu_op_and, funct3_0,
                          jump, rs_fpu, alu_src, store_src, reg_write, fpu_reg_write, result_src);
endinterface

// File: rtl/dispatch_stage_decode.sv
// Combinational translation of a decoded bundle into the word stored by the
// dispatch registers: one-hot unit enables, ALU control and pass-through fields.
module dispatch_decode
    import core_pkg::*;
(
    input  logic [DU_W-1:0]         dispatch_unit,
    input  logic [ALU_OP_W-1:0]     alu_op,
    input  logic [FUNCT3_W-1:0]     funct3,
    input  logic                    funct7_5,
    input  logic                    op_5_xor_6,
    input  logic                    jump,
    input  logic                    rs_fpu,
    input  logic                    alu_src,
    input  logic                    store_src,
    input  logic                    reg_write,
    input  logic                    fpu_reg_write,
    input  logic [RESULT_SRC_W-1:0] result_src,
    output disp_word_t              word
);

    always_comb begin
        word               = '0;
        word.unit_en       = unit_onehot(dispatch_unit);
        word.alu_op_and    = alu_op[1] & alu_op[0];
        word.funct3_0      = funct3[0];
        word.jump          = jump;
        word.rs_fpu        = rs_fpu;
        word.alu_src       = alu_src;
        word.store_src     = store_src;
        word.reg_write     = reg_write;
        word.fpu_reg_write = fpu_reg_write;
        word.result_src    = result_src;
        // Subtract variant of R-type only when bit 30 is set on an op that has it.
        case (alu_op)
            ALU_OP_ADD:   word.alu_control = ALU_CTRL_ADD;
            ALU_OP_SUB:   word.alu_control = ALU_CTRL_SUB;
            ALU_OP_FUNCT: word.alu_control = {funct7_5 & op_5_xor_6, funct3};
            default:      word.alu_control = {1'b0, funct3};
        endcase
    end

endmodule

// File: rtl/dispatch_stage.sv
// Dispatch stage: 2-entry skid buffer between decode and the execution units.
// in_ready comes straight from the skid flag, so it never sees out_ready.
module dispatch_stage
    import core_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    control_decode_io.out      dec,
    input  logic               funct7_5,
    input  logic               in_valid,
    output logic               in_ready,
    control_dispatch_io.in     disp,
    output logic               out_valid,
    input  logic               out_ready,
    input  logic               flush
);

    disp_word_t cap_word;
    disp_word_t main_q;
    disp_word_t skid_q;
    logic       main_valid;
    logic       skid_valid;
    logic       in_xfer;
    logic       main_free;

    dispatch_decode u_decode (
        .dispatch_unit (dec.dispatch_unit),
        .alu_op        (dec.alu_op),
        .funct3        (dec.funct3),
        .funct7_5      (funct7_5),
        .op_5_xor_6    (dec.op_5_xor_6),
        .jump          (dec.jump),
        .rs_fpu        (dec.rs_fpu),
        .alu_src       (dec.alu_src),
        .store_src     (dec.store_src),
        .reg_write     (dec.reg_write),
        .fpu_reg_write (dec.fpu_reg_write),
        .result_src    (dec.result_src),
        .word          (cap_word)
    );

    assign in_ready  = ~skid_valid;
    assign in_xfer   = in_valid & ~skid_valid;
    assign main_free = ~main_valid | out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (main_free) begin
            // Skid entry is older than anything on the input, so it goes first.
            if (skid_valid) begin
                main_q     <= skid_q;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else begin
                main_valid <= in_xfer;
                if (in_xfer) main_q <= cap_word;
            end
        end else if (in_xfer) begin
            skid_q     <= cap_word;
            skid_valid <= 1'b1;
        end
    end

    assign out_valid          = main_valid;
    assign disp.short_alu_en  = main_q.unit_en[DU_SHORT_ALU] & main_valid;
    assign disp.long_alu_en   = main_q.unit_en[DU_LONG_ALU]  & main_valid;
    assign disp.branch_en     = main_q.unit_en[DU_BRANCH]    & main_valid;
    assign disp.cache_re      = main_q.unit_en[DU_CACHE_RD]  & main_valid;
    assign disp.cache_we      = main_q.unit_en[DU_CACHE_WR]  & main_valid;
    assign disp.short_fpu_en  = main_q.unit_en[DU_SHORT_FPU] & main_valid;
    assign disp.long_fpu_en   = main_q.unit_en[DU_LONG_FPU]  & main_valid;
    assign disp.input_en      = main_q.unit_en[DU_INPUT]     & main_valid;
    assign disp.output_en     = main_q.unit_en[DU_OUTPUT]    & main_valid;
    assign disp.reg_write     = main_q.reg_write     & main_valid;
    assign disp.fpu_reg_write = main_q.fpu_reg_write & main_valid;
    assign disp.alu_control   = main_q.alu_control;
    assign disp.alu_op_and    = main_q.alu_op_and;
    assign disp.funct3_0      = main_q.funct3_0;
    assign disp.jump          = main_q.jump;
    assign disp.rs_fpu        = main_q.rs_fpu;
    assign disp.alu_src       = main_q.alu_src;
    assign disp.store_src     = main_q.store_src;
    assign disp.result_src    = main_q.result_src;

endmodule

// File: tb/tb_dispatch_stage.sv
// Scoreboard bench for dispatch_stage: directed scenarios followed by random
// traffic, checked against a queue-based reference model.
module tb_dispatch_stage;
    import core_pkg::*;

    logic clk = 1'b0;
    logic rst, funct7_5, in_valid, in_ready, out_valid, out_ready, flush;

    always #5 clk = ~clk;

    control_decode_io   dec_if ();
    control_dispatch_io disp_if ();

    dispatch_stage dut (
        .clk       (clk),
        .rst       (rst),
        .dec       (dec_if),
        .funct7_5  (funct7_5),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .disp      (disp_if),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .flush     (flush)
    );

    typedef struct packed {
        logic [8:0] en;
        logic [3:0] alu_control;
        logic [9:0] misc;
    } exp_t;

    exp_t       sb[$];
    int         tests = 0;
    int         fails = 0;
    logic       mon_en = 1'b0;
    logic [3:0] last_alu;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: the bundle as the units should see it, from the field rules alone.
    function automatic exp_t model_bundle();
        exp_t e;
        int du = int'(dec_if.dispatch_unit);
        int op = int'(dec_if.alu_op);
        e.en = (du <= 8) ? 9'(1 << du) : 9'd0;
        if (op == 0)      e.alu_control = 4'd0;
        else if (op == 1) e.alu_control = 4'd8;
        else if (op == 2) e.alu_control = {funct7_5 & dec_if.op_5_xor_6, dec_if.funct3};
        else              e.alu_control = {1'b0, dec_if.funct3};
        e.misc = {op == 3, dec_if.funct3[0], dec_if.jump, dec_if.rs_fpu, dec_if.alu_src,
                  dec_if.store_src, dec_if.reg_write, dec_if.fpu_reg_write, dec_if.result_src};
        return e;
    endfunction

    function automatic logic [8:0] dut_en();
        return {disp_if.output_en, disp_if.input_en, disp_if.long_fpu_en, disp_if.short_fpu_en,
                disp_if.cache_we, disp_if.cache_re, disp_if.branch_en, disp_if.long_alu_en,
                disp_if.short_alu_en};
    endfunction

    function automatic logic [9:0] dut_misc();
        return {disp_if.alu_op_and, disp_if.funct3_0, disp_if.jump, disp_if.rs_fpu,
                disp_if.alu_src, disp_if.store_src, disp_if.reg_write, disp_if.fpu_reg_write,
                disp_if.result_src};
    endfunction

    // Monitor: between edges the DUT should hold exactly what the model holds.
    exp_t mon_e;
    always @(negedge clk) begin
        #2;
        if (mon_en) begin
            chk("out_valid", 32'(out_valid), 32'(sb.size() > 0));
            chk("in_ready", 32'(in_ready), 32'(sb.size() < 2));
            if (out_valid) begin
                if (out_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_output", 32'(out_valid), 32'd0);
                    end else begin
                        mon_e = sb.pop_front();
                        chk("enables", 32'(dut_en()), 32'(mon_e.en));
                        chk("alu_control", 32'(disp_if.alu_control), 32'(mon_e.alu_control));
                        chk("passthrough", 32'(dut_misc()), 32'(mon_e.misc));
                        last_alu = disp_if.alu_control;
                    end
                end
            end else begin
                chk("idle_gating", 32'({dut_en(), disp_if.reg_write, disp_if.fpu_reg_write}), 32'd0);
            end
        end
    end

    task automatic set_dec(input int du, input int op, input int f3, input logic f75,
                           input logic x56, input logic rw);
        dec_if.dispatch_unit = 4'(du);
        dec_if.alu_op        = 2'(op);
        dec_if.funct3        = 3'(f3);
        dec_if.op_5_xor_6    = x56;
        dec_if.reg_write     = rw;
        dec_if.jump          = 1'b0;
        dec_if.rs_fpu        = 1'b0;
        dec_if.imm_src       = 3'd0;
        dec_if.alu_src       = 1'b0;
        dec_if.store_src     = 1'b0;
        dec_if.fpu_reg_write = 1'b0;
        dec_if.result_src    = 2'd0;
        funct7_5             = f75;
    endtask

    task automatic rand_dec();
        dec_if.dispatch_unit = 4'($urandom_range(0, 15));
        dec_if.alu_op        = 2'($urandom);
        dec_if.funct3        = 3'($urandom);
        dec_if.op_5_xor_6    = 1'($urandom);
        dec_if.reg_write     = 1'($urandom);
        dec_if.jump          = 1'($urandom);
        dec_if.rs_fpu        = 1'($urandom);
        dec_if.imm_src       = 3'($urandom);
        dec_if.alu_src       = 1'($urandom);
        dec_if.store_src     = 1'($urandom);
        dec_if.fpu_reg_write = 1'($urandom);
        dec_if.result_src    = 2'($urandom);
        funct7_5             = 1'($urandom);
    endtask

    // One clock: drive at posedge+1, note acceptance before the edge, update model at the edge.
    task automatic step(input logic v, input logic ordy, input logic fl, input logic r);
        exp_t e;
        logic fire;
        in_valid  = v;
        out_ready = ordy;
        flush     = fl;
        rst       = r;
        @(negedge clk);
        #1;
        fire = in_valid & in_ready;
        e    = model_bundle();
        @(posedge clk);
        if (r || fl) sb.delete();
        else if (fire) sb.push_back(e);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int du_list[4] = '{0, 1, 5, 8};
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        set_dec(0, 0, 0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        mon_en = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b1);

        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_enables", 32'(dut_en()), 32'd0);
        chk("rst_payload", 32'({disp_if.alu_control, dut_misc()}), 32'd0);

        // Streaming, no backpressure
        foreach (du_list[i]) begin
            set_dec(du_list[i], 0, 0, 1'b0, 1'b0, 1'b1);
            step(1'b1, 1'b1, 1'b0, 1'b0);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);

        // Backpressure into skid
        set_dec(2, 1, 3, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        set_dec(3, 3, 5, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        set_dec(4, 0, 0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("bp_in_ready_back", 32'(in_ready), 32'd1);

        // ALU decode with funct7_5 gating
        last_alu = 4'hf;
        set_dec(0, 2, 0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("alu_sub_variant", 32'(last_alu), 32'h8);
        last_alu = 4'hf;
        set_dec(0, 2, 0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("alu_add_variant", 32'(last_alu), 32'h0);

        // Flush with skid full and input pending
        set_dec(1, 0, 0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        set_dec(2, 0, 0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        set_dec(7, 3, 7, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        // Flush beats an input that would otherwise be accepted
        set_dec(6, 0, 0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("flush_drops_input", 32'(out_valid), 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0);

        // NOP bundle
        set_dec(12, 0, 0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("nop_valid", 32'(out_valid), 32'd1);
        chk("nop_enables", 32'(dut_en()), 32'd0);
        chk("nop_reg_write", 32'(disp_if.reg_write), 32'd1);
        step(1'b0, 1'b1, 1'b0, 1'b0);

        // Reset mid-operation
        set_dec(5, 1, 0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            rand_dec();
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 99) == 0));
        end
        for (int n = 0; n < 4; n++) step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
